// File: rtl/rr_mux_arbiter_if.sv
// Bundle of the four requester channels and the shared mux output of the
// round-robin arbiter.
interface rr_mux_arbiter_if #(
  parameter int DATA_W = 8
);
  logic [3:0]        req;
  logic [DATA_W-1:0] data_in0;
  logic [DATA_W-1:0] data_in1;
  logic [DATA_W-1:0] data_in2;
  logic [DATA_W-1:0] data_in3;
  logic [3:0]        gnt;
  logic [1:0]        sel;
  logic              valid;
  logic [DATA_W-1:0] data_out;

  modport master (
    output req, data_in0, data_in1, data_in2, data_in3,
    input  gnt, sel, valid, data_out
  );

  modport slave (
    input  req, data_in0, data_in1, data_in2, data_in3,
    output gnt, sel, valid, data_out
  );
endinterface

// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter owning the select lines of a 4:1 data mux, with a
// per-grant quantum and a one-cycle dead gap between owners.
module rr_mux_arbiter #(
  parameter int DATA_W  = 8,
  parameter int QUANTUM = 4
) (
  input logic         clk,
  input logic         reset,
  rr_mux_arbiter_if.slave bus
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] GRANT = 1'b1;

  localparam logic [7:0] QUANTUM_LAST = 8'(QUANTUM - 1);

  logic [0:0] state_q, state_d;
  logic [3:0] gnt_q, gnt_d;
  logic [1:0] sel_q, sel_d;
  logic [1:0] last_q, last_d;
  logic [7:0] cnt_q, cnt_d;

  logic [1:0] winner;
  logic       winner_found;
  logic [1:0] cand;
  logic       owner_req;
  logic       others_pending;
  logic       quantum_done;

  // Scan last+1, last+2, last+3, last so the previous owner ranks lowest.
  always_comb begin
    winner       = last_q;
    winner_found = 1'b0;
    cand         = last_q;
    for (int k = 1; k <= 4; k++) begin
      cand = last_q + 2'(k);
      if (!winner_found && bus.req[cand]) begin
        winner       = cand;
        winner_found = 1'b1;
      end
    end
  end

  assign owner_req      = bus.req[sel_q];
  assign others_pending = |(bus.req & ~gnt_q);
  assign quantum_done   = (cnt_q == QUANTUM_LAST);

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    sel_d   = sel_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        gnt_d = 4'b0000;
        cnt_d = 8'd0;
        if (winner_found) begin
          state_d = GRANT;
          gnt_d   = 4'b0001 << winner;
          sel_d   = winner;
          last_d  = winner;
        end
      end
      GRANT: begin
        if (!owner_req || (quantum_done && others_pending)) begin
          state_d = IDLE;
          gnt_d   = 4'b0000;
          cnt_d   = 8'd0;
        end else if (quantum_done) begin
          // Nobody else is waiting: renew the quantum without a gap.
          cnt_d = 8'd0;
        end else if (cnt_q != 8'hFF) begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = 4'b0000;
        cnt_d   = 8'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      gnt_q   <= 4'b0000;
      sel_q   <= 2'd0;
      last_q  <= 2'd3;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.gnt   = gnt_q;
  assign bus.sel   = sel_q;
  assign bus.valid = |gnt_q;

  // Data path stays zero whenever the channel has no owner.
  always_comb begin
    bus.data_out = '0;
    if (|gnt_q) begin
      case (sel_q)
        2'd0:    bus.data_out = bus.data_in0;
        2'd1:    bus.data_out = bus.data_in1;
        2'd2:    bus.data_out = bus.data_in2;
        default: bus.data_out = bus.data_in3;
      endcase
    end
  end

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Directed scoreboard bench for rr_mux_arbiter: stimulus queues the expected
// response of each cycle and an independent monitor pops and compares.
module tb_rr_mux_arbiter;

  logic clk = 1'b0;
  logic reset;

  rr_mux_arbiter_if #(.DATA_W(8)) bus ();

  rr_mux_arbiter #(.DATA_W(8), .QUANTUM(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] gnt;
    logic [1:0] sel;
    logic [7:0] data;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] data_tbl [4];
  int         n_checks = 0;
  int         n_fail   = 0;

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // One cycle of stimulus plus the outputs expected right after the next edge.
  task automatic applyStimulus(input logic rst, input logic [3:0] r,
                               input logic [3:0] eg, input logic [1:0] es);
    exp_t e;
    @(negedge clk);
    reset   = rst;
    bus.req = r;
    e.gnt   = eg;
    e.sel   = es;
    e.data  = (eg == 4'b0000) ? 8'h00 : data_tbl[es];
    exp_q.push_back(e);
  endtask

  function automatic logic [1:0] index_of(input logic [3:0] g);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 0; i < 4; i++)
      if (g[i]) idx = 2'(i);
    return idx;
  endfunction

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checkOutput("gnt", 32'(bus.gnt), 32'(e.gnt));
        checkOutput("sel", 32'(bus.sel), 32'(e.sel));
        checkOutput("valid", 32'(bus.valid), 32'(e.gnt != 4'b0000));
        checkOutput("data_out", 32'(bus.data_out), 32'(e.data));
        checkOutput("gnt_onehot0", 32'($onehot0(bus.gnt)), 32'd1);
        if (bus.valid)
          checkOutput("sel_index", 32'(bus.sel), 32'(index_of(bus.gnt)));
        else
          checkOutput("data_masked", 32'(bus.data_out), 32'd0);
      end
    end
  end

  initial begin : stimulus
    int guard;
    data_tbl[0]  = 8'hA5;
    data_tbl[1]  = 8'hB6;
    data_tbl[2]  = 8'hC7;
    data_tbl[3]  = 8'hD8;
    reset        = 1'b1;
    bus.req      = 4'b0000;
    bus.data_in0 = data_tbl[0];
    bus.data_in1 = data_tbl[1];
    bus.data_in2 = data_tbl[2];
    bus.data_in3 = data_tbl[3];

    // Reset, then a single requester that later drops.
    applyStimulus(1'b1, 4'b0000, 4'b0000, 2'd0);
    applyStimulus(1'b1, 4'b0000, 4'b0000, 2'd0);
    applyStimulus(1'b0, 4'b0000, 4'b0000, 2'd0);
    applyStimulus(1'b0, 4'b0001, 4'b0001, 2'd0);
    applyStimulus(1'b0, 4'b0001, 4'b0001, 2'd0);
    applyStimulus(1'b0, 4'b0000, 4'b0000, 2'd0);
    applyStimulus(1'b0, 4'b0000, 4'b0000, 2'd0);

    // All four requesting: 4 cycles each, one dead cycle between owners.
    applyStimulus(1'b1, 4'b1111, 4'b0000, 2'd0);
    for (int o = 0; o < 5; o++) begin
      for (int c = 0; c < 4; c++)
        applyStimulus(1'b0, 4'b1111, 4'(1 << (o % 4)), 2'(o % 4));
      if (o < 4)
        applyStimulus(1'b0, 4'b1111, 4'b0000, 2'(o));
    end

    // Lone requester keeps the channel across quantum boundaries.
    applyStimulus(1'b1, 4'b0000, 4'b0000, 2'd0);
    for (int c = 0; c < 10; c++)
      applyStimulus(1'b0, 4'b0100, 4'b0100, 2'd2);
    applyStimulus(1'b0, 4'b0101, 4'b0100, 2'd2);
    applyStimulus(1'b0, 4'b0101, 4'b0100, 2'd2);
    applyStimulus(1'b0, 4'b0101, 4'b0000, 2'd2);
    applyStimulus(1'b0, 4'b0101, 4'b0001, 2'd0);

    // Early release by owner 1 while requester 3 waits.
    applyStimulus(1'b1, 4'b0000, 4'b0000, 2'd0);
    applyStimulus(1'b0, 4'b0010, 4'b0010, 2'd1);
    applyStimulus(1'b0, 4'b1010, 4'b0010, 2'd1);
    applyStimulus(1'b0, 4'b1000, 4'b0000, 2'd1);
    applyStimulus(1'b0, 4'b1000, 4'b1000, 2'd3);
    applyStimulus(1'b0, 4'b1000, 4'b1000, 2'd3);

    // Reset in the middle of a grant, then requester 0 wins first.
    applyStimulus(1'b0, 4'b0000, 4'b0000, 2'd3);
    applyStimulus(1'b0, 4'b0010, 4'b0010, 2'd1);
    applyStimulus(1'b0, 4'b0010, 4'b0010, 2'd1);
    applyStimulus(1'b1, 4'b1111, 4'b0000, 2'd0);
    applyStimulus(1'b0, 4'b1111, 4'b0001, 2'd0);
    applyStimulus(1'b0, 4'b1111, 4'b0001, 2'd0);

    guard = 0;
    while (exp_q.size() != 0 && guard < 10) begin
      @(posedge clk);
      #2;
      guard++;
    end
    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("[TB] FAIL drain: %0d entries left, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rr_mux_arbiter.md
Name: rr_mux_arbiter

Overview:
- Round-robin arbiter that shares one 4:1 data mux channel among four requesters.
- Registers the grant and the mux select, and enforces a per-grant quantum so no requester can hold the channel indefinitely.
- Inserts a one-cycle dead (break-before-make) gap between owners.
- Sits in front of the 4:1 mux datapath and is its only source of select lines.

Parameters:
- DATA_W, 8, width of each requester data bus and of data_out.
- QUANTUM, 4, maximum consecutive grant cycles while another requester is pending; legal range 1..255.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- req  input  4  request per requester; bit i is held high while requester i wants the channel.
- data_in0  input  DATA_W  data from requester 0.
- data_in1  input  DATA_W  data from requester 1.
- data_in2  input  DATA_W  data from requester 2.
- data_in3  input  DATA_W  data from requester 3.
- gnt  output  4  one-hot grant, registered; all zero when no owner.
- sel  output  2  mux select (s1 = sel[1], s0 = sel[0]), registered; equals the owner index.
- valid  output  1  high while an owner holds the channel (valid = |gnt).
- data_out  output  DATA_W  selected data; combinational from sel and data_inN; forced to 0 when valid = 0.

Behaviour:
- State machine has two states, IDLE and GRANT.
- Internal registers:
  - last, 2 bits: index of the most recent owner.
  - cnt, 8 bits: cycles the current owner has held the channel.
- Reset: synchronous on reset = 1 at a rising edge. State = IDLE, gnt = 0, sel = 0, valid = 0, data_out = 0, cnt = 0, last = 3 (so requester 0 has first priority). Reset dominates every other input in any state, including mid-grant: the next cycle shows gnt = 0.
- IDLE:
  - gnt = 0.
  - If req != 0, select the first set bit scanning last+1, last+2, last+3, last (mod 4).
  - At the next edge: state = GRANT, gnt = onehot(winner), sel = winner, last = winner, cnt = 0.
  - Latency is one cycle from req sampled high in IDLE to gnt high.
  - If req = 0, remain in IDLE.
- GRANT (owner o = sel): cnt increments by 1 each cycle, saturating at 255.
  - Release when req[o] = 0, or when cnt = QUANTUM-1 and any other req bit is set.
  - On release, at the next edge: state = IDLE, gnt = 0, cnt = 0.
  - The IDLE cycle is the mandatory dead cycle; re-arbitration occurs in that cycle.
  - Quantum expiry with no other requester pending: stay in GRANT and reset cnt to 0. The owner keeps the channel with no gap.
  - Simultaneous events (req[o] drops in the same cycle the quantum expires): treat as a single release.
  - A released owner still requesting is lowest priority in the following arbitration, because last = o.
- sel holds its last value in IDLE; data_out is masked to 0 by valid.
- gnt is always one-hot or zero; sel always equals the index of the set gnt bit when valid = 1.
- Requests that are high for less than one sampled edge in IDLE are not guaranteed service. No request latching is performed.

Test Plan:
- Reset then single requester: reset 2 cycles; req = 0001, data_in0 = 8'hA5 → gnt = 0001, sel = 0, data_out = 8'hA5 one cycle after req. Drop req → gnt = 0000, data_out = 0 on the next cycle.
- Round robin: req = 1111 held, QUANTUM = 4 → owners in order 0,1,2,3,0. Each owner holds 4 cycles with gnt = 0 for exactly 1 cycle between owners.
- Quantum with lone requester: req = 0100 held 20 cycles → gnt = 0100 continuously, no gap cycles. Assert req = 0101 at cycle 10 → owner 2 released after at most QUANTUM cycles, then 1 dead cycle, then gnt = 0001.
- Early release: owner 1 drops req after 2 cycles while req[3] = 1 → dead cycle, then gnt = 1000, sel = 3.
- Reset mid-grant: reset asserted during gnt = 0010 → next cycle gnt = 0, valid = 0. With req = 1111 after reset release → first grant goes to requester 0.
- Checker on every cycle asserts gnt one-hot-or-zero, sel == index(gnt) when valid, data_out == 0 when !valid.
